// File: rtl/sseg_pkg.sv
// Shared state encoding and digit width for the seven-segment scan controller.
package sseg_pkg;

    localparam int unsigned SSEG_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } sseg_state_t;

endpackage

// File: rtl/sseg_prescaler.sv
// Slot counter for the scanner. SlotStart and InBlank are look-ahead flags:
// they describe where the counter will be after the coming clock edge.
module sseg_prescaler #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK    = 4
) (
    input  logic Clk,
    input  logic Clear,
    output logic SlotStart,
    output logic InBlank
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (Clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        cnt_q <= cnt_d;
    end

    // Next edge begins a new slot / next edge still lands inside the blank window.
    assign SlotStart = (cnt_q == CNT_LAST);
    assign InBlank   = (cnt_q < BLANK_LAST);

endmodule

// File: rtl/sseg_scanner.sv
// Time-multiplexed seven-segment scan controller with per-slot blanking gap.
// Define SSEG_SCANNER_LZB_EN to enable leading-zero blanking.
module sseg_scanner
    import sseg_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK    = 4
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             Enable,
    input  logic                             Load,
    input  logic [SSEG_DIGIT_W*DIGITS-1:0]   Value,
    input  logic [DIGITS-1:0]                DpMask,
    output logic [SSEG_DIGIT_W-1:0]          Num,
    output logic                             Dp,
    output logic [DIGITS-1:0]                Anode
);

    localparam int unsigned IW = $clog2(DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    sseg_state_t                      state_q, state_d;
    logic [IW-1:0]                    idx_q, idx_d;
    logic [SSEG_DIGIT_W*DIGITS-1:0]   val_q, val_d;
    logic [DIGITS-1:0]                dpm_q, dpm_d;
    logic [SSEG_DIGIT_W-1:0]          num_q, num_d;
    logic                             dp_q, dp_d;
    logic [DIGITS-1:0]                anode_q, anode_d;
    logic                             sup_q, sup_d;
    logic [DIGITS-1:0]                sup_vec;
    logic                             latch;
    logic [IW-1:0]                    lidx;
    logic                             slot_start;
    logic                             in_blank;
    logic                             cnt_clear;

    assign cnt_clear = Reset || !Enable || (state_q == ST_IDLE);

    sseg_prescaler #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_prescaler (
        .Clk       (Clk),
        .Clear     (cnt_clear),
        .SlotStart (slot_start),
        .InBlank   (in_blank)
    );

    // Slot-start latching reads the post-load shadow so a coincident Load is bypassed.
    assign val_d = Load ? Value  : val_q;
    assign dpm_d = Load ? DpMask : dpm_q;

`ifdef SSEG_SCANNER_LZB_EN
    logic [DIGITS-1:0] zero_from;

    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (val_d[SSEG_DIGIT_W*(DIGITS-1) +: SSEG_DIGIT_W] == '0);
        for (int unsigned k = 1; k < DIGITS; k++) begin
            zero_from[DIGITS-1-k] = zero_from[DIGITS-k]
                && (val_d[SSEG_DIGIT_W*(DIGITS-1-k) +: SSEG_DIGIT_W] == '0);
        end
        sup_vec = zero_from & ~dpm_d;
        sup_vec[0] = 1'b0;
    end
`else
    assign sup_vec = '0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        dp_d    = dp_q;
        anode_d = anode_q;
        sup_d   = sup_q;
        latch   = 1'b0;
        lidx    = idx_q;

        if (!Enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            anode_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    idx_d   = '0;
                    lidx    = '0;
                    latch   = 1'b1;
                    anode_d = '0;
                end
                ST_BLANK, ST_SHOW: begin
                    if (slot_start) begin
                        lidx    = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                        idx_d   = lidx;
                        state_d = ST_BLANK;
                        latch   = 1'b1;
                        anode_d = '0;
                    end else if ((state_q == ST_BLANK) && !in_blank) begin
                        state_d        = ST_SHOW;
                        anode_d        = '0;
                        anode_d[idx_q] = !sup_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    anode_d = '0;
                end
            endcase
        end

        if (latch) begin
            num_d = val_d[SSEG_DIGIT_W*lidx +: SSEG_DIGIT_W];
            dp_d  = dpm_d[lidx];
            sup_d = sup_vec[lidx];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            val_q   <= '0;
            dpm_q   <= '0;
            num_q   <= '0;
            dp_q    <= 1'b0;
            anode_q <= '0;
            sup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            dpm_q   <= dpm_d;
            num_q   <= num_d;
            dp_q    <= dp_d;
            anode_q <= anode_d;
            sup_q   <= sup_d;
        end
    end

    assign Num   = num_q;
    assign Dp    = dp_q;
    assign Anode = anode_q;

endmodule

// File: tb/tb_sseg_scanner.sv
// Scoreboard bench for sseg_scanner with DIGITS=4, PRESCALE=8, BLANK=2.
module tb_sseg_scanner;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned PRESCALE = 8;
    localparam int unsigned BLANK    = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        Load;
    logic [15:0] Value;
    logic [3:0]  DpMask;
    logic [3:0]  Num;
    logic        Dp;
    logic [3:0]  Anode;

    typedef struct {
        logic [3:0] num;
        logic       dp;
        logic [3:0] anode;
    } slot_t;

    slot_t       sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    sseg_scanner #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Enable (Enable),
        .Load   (Load),
        .Value  (Value),
        .DpMask (DpMask),
        .Num    (Num),
        .Dp     (Dp),
        .Anode  (Anode)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reset for one edge, then present Load/Enable so edge 1 loads and starts slot 0.
    task automatic start_scan(input logic [15:0] v, input logic [3:0] m);
        Reset  = 1'b1;
        Enable = 1'b0;
        Load   = 1'b0;
        tick();
        Reset  = 1'b0;
        Enable = 1'b1;
        Load   = 1'b1;
        Value  = v;
        DpMask = m;
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        Enable = 1'b0;
        Load   = 1'b0;
        Value  = '0;
        DpMask = '0;
        tick();
        n_tests++;
        if (Num !== 4'h0 || Dp !== 1'b0 || Anode !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got num=%h dp=%b anode=%b, want num=0 dp=0 anode=0000", Num, Dp, Anode);
        end
        start_scan(16'h1234, 4'b0010);
        for (int i = 0; i < 19; i++) begin
            tick();
            if (i == 0) Load = 1'b0;
        end
        n_tests++;
        if (Anode !== 4'b0100 || Num !== 4'h2) begin
            n_fail++;
            $display("FAIL reset_pre_show: got num=%h anode=%b, want num=2 anode=0100", Num, Anode);
        end
        Reset = 1'b1;
        tick();
        n_tests++;
        if (Num !== 4'h0 || Dp !== 1'b0 || Anode !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_show: got num=%h dp=%b anode=%b, want num=0 dp=0 anode=0000", Num, Dp, Anode);
        end
        Reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_tests++;
            if (Num !== 4'h0 || Anode !== ((e == 3) ? 4'b0001 : 4'b0000)) begin
                n_fail++;
                $display("FAIL reset_restart_edge%0d: got num=%h anode=%b, want num=0 anode=%b",
                         e, Num, Anode, (e == 3) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_scan();
        slot_t      e;
        logic [3:0] exp_an;
        start_scan(16'h1234, 4'b0010);
        sb.push_back('{num: 4'h4, dp: 1'b0, anode: 4'b0001});
        sb.push_back('{num: 4'h3, dp: 1'b1, anode: 4'b0010});
        sb.push_back('{num: 4'h2, dp: 1'b0, anode: 4'b0100});
        sb.push_back('{num: 4'h1, dp: 1'b0, anode: 4'b1000});
        sb.push_back('{num: 4'h4, dp: 1'b0, anode: 4'b0001});
        for (int s = 0; s < 5; s++) begin
            e = sb.pop_front();
            for (int c = 0; c < int'(PRESCALE); c++) begin
                tick();
                if (s == 0 && c == 0) Load = 1'b0;
                exp_an = (c < int'(BLANK)) ? 4'b0000 : e.anode;
                n_tests++;
                if (Anode !== exp_an || Num !== e.num || Dp !== e.dp) begin
                    n_fail++;
                    $display("FAIL scan s%0d c%0d: got num=%h dp=%b anode=%b, want num=%h dp=%b anode=%b",
                             s, c, Num, Dp, Anode, e.num, e.dp, exp_an);
                end
            end
        end
    endtask

    task automatic test_load_midslot();
        slot_t      e;
        logic [3:0] exp_an;
        start_scan(16'h1234, 4'b0010);
        sb.push_back('{num: 4'h4, dp: 1'b0, anode: 4'b0001});
        sb.push_back('{num: 4'h3, dp: 1'b1, anode: 4'b0010});
        for (int s = 0; s < 5; s++) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL load_mid sb_underflow: got 0 entries, want >=1");
                break;
            end
            e = sb.pop_front();
            for (int c = 0; c < int'(PRESCALE); c++) begin
                tick();
                if (s == 0 && c == 0) Load = 1'b0;
                if (s == 1 && c == 4) Load = 1'b0;
                exp_an = (c < int'(BLANK)) ? 4'b0000 : e.anode;
                n_tests++;
                if (Anode !== exp_an || Num !== e.num || Dp !== e.dp) begin
                    n_fail++;
                    $display("FAIL load_mid s%0d c%0d: got num=%h dp=%b anode=%b, want num=%h dp=%b anode=%b",
                             s, c, Num, Dp, Anode, e.num, e.dp, exp_an);
                end
                if (s == 1 && c == 3) begin
                    Load  = 1'b1;
                    Value = 16'hABCD;
                    sb.push_back('{num: 4'hB, dp: 1'b0, anode: 4'b0100});
                    sb.push_back('{num: 4'hA, dp: 1'b0, anode: 4'b1000});
                    sb.push_back('{num: 4'hD, dp: 1'b0, anode: 4'b0001});
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        slot_t      e;
        logic [3:0] exp_an;
        start_scan(16'h1234, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) Load = 1'b0;
        end
        n_tests++;
        if (Anode !== 4'b0001) begin
            n_fail++;
            $display("FAIL en_pre_show: got anode=%b, want anode=0001", Anode);
        end
        Enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (Anode !== 4'b0000 || Num !== 4'h4 || Dp !== 1'b0) begin
                n_fail++;
                $display("FAIL en_off_%0d: got num=%h dp=%b anode=%b, want num=4 dp=0 anode=0000", i, Num, Dp, Anode);
            end
        end
        Enable = 1'b1;
        sb.push_back('{num: 4'h4, dp: 1'b0, anode: 4'b0001});
        sb.push_back('{num: 4'h3, dp: 1'b1, anode: 4'b0010});
        for (int s = 0; s < 2; s++) begin
            e = sb.pop_front();
            for (int c = 0; c < int'(PRESCALE); c++) begin
                tick();
                exp_an = (c < int'(BLANK)) ? 4'b0000 : e.anode;
                n_tests++;
                if (Anode !== exp_an || Num !== e.num || Dp !== e.dp) begin
                    n_fail++;
                    $display("FAIL en_restart s%0d c%0d: got num=%h dp=%b anode=%b, want num=%h dp=%b anode=%b",
                             s, c, Num, Dp, Anode, e.num, e.dp, exp_an);
                end
            end
        end
    endtask

`ifdef SSEG_SCANNER_LZB_EN
    task automatic test_lzb();
        slot_t      e;
        logic [3:0] exp_an;
        logic [15:0] vals [3];
        logic [3:0]  masks [3];
        vals[0] = 16'h0050; masks[0] = 4'b0000;
        vals[1] = 16'h0000; masks[1] = 4'b0000;
        vals[2] = 16'h0000; masks[2] = 4'b1000;
        for (int r = 0; r < 3; r++) begin
            start_scan(vals[r], masks[r]);
            if (r == 0) begin
                sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0001});
                sb.push_back('{num: 4'h5, dp: 1'b0, anode: 4'b0010});
                sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0000});
                sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0000});
            end else if (r == 1) begin
                sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0001});
                sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0000});
                sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0000});
                sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0000});
            end else begin
                sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0001});
                sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0000});
                sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0000});
                sb.push_back('{num: 4'h0, dp: 1'b1, anode: 4'b1000});
            end
            for (int s = 0; s < 4; s++) begin
                e = sb.pop_front();
                for (int c = 0; c < int'(PRESCALE); c++) begin
                    tick();
                    if (s == 0 && c == 0) Load = 1'b0;
                    exp_an = (c < int'(BLANK)) ? 4'b0000 : e.anode;
                    n_tests++;
                    if (Anode !== exp_an || Num !== e.num || Dp !== e.dp) begin
                        n_fail++;
                        $display("FAIL lzb r%0d s%0d c%0d: got num=%h dp=%b anode=%b, want num=%h dp=%b anode=%b",
                                 r, s, c, Num, Dp, Anode, e.num, e.dp, exp_an);
                    end
                end
            end
        end
    endtask
`else
    task automatic test_zero_no_lzb();
        slot_t      e;
        logic [3:0] exp_an;
        start_scan(16'h0000, 4'b0000);
        sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0001});
        sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0010});
        sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b0100});
        sb.push_back('{num: 4'h0, dp: 1'b0, anode: 4'b1000});
        for (int s = 0; s < 4; s++) begin
            e = sb.pop_front();
            for (int c = 0; c < int'(PRESCALE); c++) begin
                tick();
                if (s == 0 && c == 0) Load = 1'b0;
                exp_an = (c < int'(BLANK)) ? 4'b0000 : e.anode;
                n_tests++;
                if (Anode !== exp_an || Num !== e.num || Dp !== e.dp) begin
                    n_fail++;
                    $display("FAIL zero s%0d c%0d: got num=%h dp=%b anode=%b, want num=%h dp=%b anode=%b",
                             s, c, Num, Dp, Anode, e.num, e.dp, exp_an);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_load_midslot();
        test_enable_drop();
`ifdef SSEG_SCANNER_LZB_EN
        test_lzb();
`else
        test_zero_no_lzb();
`endif
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained: got %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
